// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer: SPI core register map,
// CTRL bit positions, sequencer states and small word-building helpers.
package spi_seq_pkg;

  localparam logic [4:0] ADR_TX0  = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  localparam int CTRL_GO     = 8;
  localparam int CTRL_RX_NEG = 9;
  localparam int CTRL_TX_NEG = 10;
  localparam int CTRL_LSB    = 11;
  localparam int CTRL_IE     = 12;
  localparam int CTRL_ASS    = 13;

  typedef enum logic [3:0] {
    IDLE, WR_DIV, WR_TX, WR_SS, WR_CTRL, WAIT, POLL, RD_RX, RESP
  } seq_state_e;

  // 0 and anything above 32 mean a full 32-bit character
  function automatic logic [5:0] norm_len(input logic [5:0] len);
    return (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
  endfunction

  function automatic logic [31:0] len_mask(input logic [5:0] len);
    return (len >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
  endfunction

  function automatic logic [31:0] ctrl_word(input logic [5:0] len, input logic [2:0] mode,
                                            input logic ie);
    logic [31:0] w;
    w = '0;
    w[6:0]        = {1'b0, len};
    w[CTRL_GO]     = 1'b1;
    w[CTRL_RX_NEG] = mode[0];
    w[CTRL_TX_NEG] = mode[1];
    w[CTRL_LSB]    = mode[2];
    w[CTRL_IE]     = ie;
    w[CTRL_ASS]    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/spi_seq_rr_arb.sv
// N-way round-robin arbiter. Search starts at the requester after the last
// grant; the pointer only moves when the caller accepts the grant (adv_i).
module spi_seq_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] last_q, last_d;
  logic [IW:0]   cand;

  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!gnt_vld_o && req_i[cand[IW-1:0]]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (adv_i && gnt_vld_o) last_d = gnt_idx_o;
  end

  // Pointer resets to the last requester so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IW'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Wishbone master that runs one SPI core word transfer per grant for N_REQ requesters.
// Define SPI_SEQ_POLL_EN to poll CTRL.GO for completion instead of waiting on spi_int_i.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SS_NB = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [32*N_REQ-1:0]  req_tx_i,
  input  logic [6*N_REQ-1:0]   req_len_i,
  input  logic [5*N_REQ-1:0]   req_ss_i,
  input  logic [15:0]          cfg_divider_i,
  input  logic [2:0]           cfg_mode_i,
  output logic [N_REQ-1:0]     done_o,
  output logic [31:0]          rx_data_o,
  output logic                 busy_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [4:0]           m_adr_o,
  output logic [31:0]          m_dat_o,
  output logic [3:0]           m_sel_o,
  input  logic [31:0]          m_dat_i,
  input  logic                 m_ack_i,
  input  logic                 spi_int_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef SPI_SEQ_POLL_EN
  localparam logic IE_VAL = 1'b0;
  logic unused_int;
  assign unused_int = spi_int_i;
`else
  localparam logic IE_VAL = 1'b1;
`endif

  seq_state_e        state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [31:0]       tx_q, tx_d;
  logic [5:0]        len_q, len_d;
  logic [4:0]        ss_q, ss_d;
  logic [15:0]       div_q, div_d;
  logic [2:0]        mode_q, mode_d;
  logic [15:0]       shadow_q, shadow_d;
  logic              shadow_vld_q, shadow_vld_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [4:0]        adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [31:0]       rx_q, rx_d;

  logic [31:0] tx_arr  [N_REQ];
  logic [5:0]  len_arr [N_REQ];
  logic [4:0]  ss_arr  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign tx_arr[gi]  = req_tx_i[gi*32 +: 32];
    assign len_arr[gi] = req_len_i[gi*6 +: 6];
    assign ss_arr[gi]  = req_ss_i[gi*5 +: 5];
  end

  logic [IW-1:0] arb_idx;
  logic          arb_vld;
  logic          arb_adv;

  spi_seq_rr_arb #(.N(N_REQ), .IW(IW)) u_arb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req_i     (req_i),
    .adv_i     (arb_adv),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  // Slave indices beyond the core's select width select nobody
  logic [31:0] ss_word;
  assign ss_word = ({27'd0, ss_q} < 32'(SS_NB)) ? (32'd1 << ss_q) : 32'd0;

  logic        acc_we, acc_done;
  logic [4:0]  acc_adr;
  logic [31:0] acc_dat;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    tx_d         = tx_q;
    len_d        = len_q;
    ss_d         = ss_q;
    div_d        = div_q;
    mode_d       = mode_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    done_d       = '0;
    rx_d         = rx_q;
    arb_adv      = 1'b0;
    acc_we       = 1'b1;
    acc_adr      = ADR_TX0;
    acc_dat      = '0;
    acc_done     = cyc_q && m_ack_i;

    case (state_q)
      WR_DIV:  begin acc_adr = ADR_DIV;  acc_dat = {16'd0, div_q}; end
      WR_TX:   begin acc_adr = ADR_TX0;  acc_dat = tx_q; end
      WR_SS:   begin acc_adr = ADR_SS;   acc_dat = ss_word; end
      WR_CTRL: begin acc_adr = ADR_CTRL; acc_dat = ctrl_word(len_q, mode_q, IE_VAL); end
      POLL:    begin acc_we = 1'b0; acc_adr = ADR_CTRL; end
      RD_RX:   begin acc_we = 1'b0; acc_adr = ADR_TX0; end
      default: ;
    endcase

    // Access states start a strobe whenever the bus is idle, which gives one
    // dead cycle after every ack before the next access
    if (state_q != IDLE && state_q != WAIT && state_q != RESP && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = acc_we;
      adr_d = acc_adr;
      dat_d = acc_dat;
    end
    if (acc_done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          arb_adv = 1'b1;
          gnt_d   = arb_idx;
          tx_d    = tx_arr[arb_idx];
          len_d   = norm_len(len_arr[arb_idx]);
          ss_d    = ss_arr[arb_idx];
          div_d   = cfg_divider_i;
          mode_d  = cfg_mode_i;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          if (!shadow_vld_q || shadow_q != cfg_divider_i) begin
            state_d = WR_DIV;
            adr_d   = ADR_DIV;
            dat_d   = {16'd0, cfg_divider_i};
          end else begin
            state_d = WR_TX;
            adr_d   = ADR_TX0;
            dat_d   = tx_arr[arb_idx];
          end
        end
      end
      WR_DIV: if (acc_done) begin
        shadow_d     = div_q;
        shadow_vld_d = 1'b1;
        state_d      = WR_TX;
      end
      WR_TX:  if (acc_done) state_d = WR_SS;
      WR_SS:  if (acc_done) state_d = WR_CTRL;
`ifdef SPI_SEQ_POLL_EN
      WR_CTRL: if (acc_done) state_d = POLL;
`else
      WR_CTRL: if (acc_done) state_d = WAIT;
      WAIT:    if (spi_int_i) state_d = RD_RX;
`endif
      POLL: if (acc_done && !m_dat_i[CTRL_GO]) state_d = RD_RX;
      RD_RX: if (acc_done) begin
        rx_d          = m_dat_i & len_mask(len_q);
        done_d[gnt_q] = 1'b1;
        state_d       = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      tx_q         <= '0;
      len_q        <= '0;
      ss_q         <= '0;
      div_q        <= '0;
      mode_q       <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      done_q       <= '0;
      rx_q         <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      tx_q         <= tx_d;
      len_q        <= len_d;
      ss_q         <= ss_d;
      div_q        <= div_d;
      mode_q       <= mode_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      done_q       <= done_d;
      rx_q         <= rx_d;
    end
  end

  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = cyc_q;
  assign m_we_o    = we_q;
  assign m_adr_o   = adr_q;
  assign m_dat_o   = dat_q;
  assign m_sel_o   = cyc_q ? 4'hF : 4'h0;
  assign done_o    = done_q;
  assign rx_data_o = rx_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a behavioural SPI core register model.
// Also builds with SPI_SEQ_POLL_EN to exercise the CTRL polling path.
module tb_spi_xfer_sequencer;

  localparam int N = 2;
`ifdef SPI_SEQ_POLL_EN
  localparam logic [31:0] IE_V = 32'h0000_0000;
  localparam int POLL_READS = 4;
`else
  localparam logic [31:0] IE_V = 32'h0000_1000;
  localparam int POLL_READS = 0;
`endif

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [N-1:0]  req_i;
  logic [32*N-1:0] req_tx_i;
  logic [6*N-1:0]  req_len_i;
  logic [5*N-1:0]  req_ss_i;
  logic [15:0]   cfg_divider_i;
  logic [2:0]    cfg_mode_i;
  logic [N-1:0]  done_o;
  logic [31:0]   rx_data_o;
  logic          busy_o;
  logic          m_cyc_o, m_stb_o, m_we_o;
  logic [4:0]    m_adr_o;
  logic [31:0]   m_dat_o;
  logic [3:0]    m_sel_o;
  logic [31:0]   m_dat_i = 32'h0;
  logic          m_ack_i = 1'b0;
  logic          spi_int_i = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  spi_xfer_sequencer #(.N_REQ(N), .SS_NB(32)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .req_i         (req_i),
    .req_tx_i      (req_tx_i),
    .req_len_i     (req_len_i),
    .req_ss_i      (req_ss_i),
    .cfg_divider_i (cfg_divider_i),
    .cfg_mode_i    (cfg_mode_i),
    .done_o        (done_o),
    .rx_data_o     (rx_data_o),
    .busy_o        (busy_o),
    .m_cyc_o       (m_cyc_o),
    .m_stb_o       (m_stb_o),
    .m_we_o        (m_we_o),
    .m_adr_o       (m_adr_o),
    .m_dat_o       (m_dat_o),
    .m_sel_o       (m_sel_o),
    .m_dat_i       (m_dat_i),
    .m_ack_i       (m_ack_i),
    .spi_int_i     (spi_int_i)
  );

  // SPI core model: acks every strobe one cycle later, logs writes
  logic [37:0] wr_log[$];
  int          rx_reads = 0;
  int          ctrl_reads = 0;
  int          int_cnt = 0;
  int          go_left = 0;
  logic [31:0] miso = 32'h0;
  logic        hold_int = 1'b0;

  always @(posedge wb_clk_i) begin
    m_ack_i <= 1'b0;
    if (int_cnt > 0) begin
      int_cnt <= int_cnt - 1;
      if (int_cnt == 1 && !hold_int) spi_int_i <= 1'b1;
    end
    if (m_cyc_o && m_stb_o && !m_ack_i) begin
      m_ack_i <= 1'b1;
      if (m_we_o) begin
        wr_log.push_back({1'b1, m_adr_o, m_dat_o});
        if (m_adr_o == 5'h10) begin
          int_cnt <= 5;
          go_left <= 3;
        end
      end else if (m_adr_o == 5'h00) begin
        m_dat_i   <= miso;
        rx_reads  <= rx_reads + 1;
        spi_int_i <= 1'b0;
      end else if (m_adr_o == 5'h10) begin
        ctrl_reads <= ctrl_reads + 1;
        m_dat_i    <= (go_left > 0 || hold_int) ? 32'h0000_0100 : 32'h0;
        if (go_left > 0) go_left <= go_left - 1;
      end
    end
  end

  // Bus protocol monitor
  logic        prev_cyc = 1'b0, prev_ack = 1'b0;
  logic [37:0] prev_bus = '0;
  int          viol = 0;

  always @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (m_stb_o !== m_cyc_o) viol <= viol + 1;
      else if (m_cyc_o && m_sel_o !== 4'hF) viol <= viol + 1;
      else if (prev_cyc && !prev_ack &&
               (!m_cyc_o || {m_we_o, m_adr_o, m_dat_o} !== prev_bus)) viol <= viol + 1;
      else if (prev_cyc && prev_ack && m_cyc_o) viol <= viol + 1;
    end
    prev_cyc <= m_cyc_o;
    prev_ack <= m_ack_i;
    prev_bus <= {m_we_o, m_adr_o, m_dat_o};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge wb_clk_i); #1;
      if (done_o != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic reset_dut();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check_eq("rst_ctl", {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, done_o, busy_o}, 64'd0);
    check_eq("rst_dat", {m_dat_o, rx_data_o}, 64'd0);
    wb_rst_i = 1'b0;
  endtask

  task automatic run_one(input int idx, input logic [31:0] tx, input logic [5:0] len,
                         input logic [4:0] ss, input logic [15:0] div, input logic [2:0] mode,
                         input logic [31:0] miso_w, input logic [31:0] ctrl_noie,
                         input logic [31:0] ss_exp, input logic div_wr, input logic [31:0] rx_exp);
    int   base, rb, cb, k;
    logic ok;
    base = wr_log.size();
    rb   = rx_reads;
    cb   = ctrl_reads;
    req_tx_i[idx*32 +: 32] = tx;
    req_len_i[idx*6 +: 6]  = len;
    req_ss_i[idx*5 +: 5]   = ss;
    cfg_divider_i = div;
    cfg_mode_i    = mode;
    miso          = miso_w;
    req_i[idx]    = 1'b1;
    check_eq("stb_before", {63'd0, m_stb_o}, 64'd0);
    @(posedge wb_clk_i); #1;
    check_eq("stb_first", {62'd0, m_stb_o, busy_o}, 64'd3);
    wait_done(ok);
    check_eq("done", {62'd0, done_o}, 64'd1 << idx);
    check_eq("rx", {32'd0, rx_data_o}, {32'd0, rx_exp});
    check_eq("busy_resp", {63'd0, busy_o}, 64'd1);
    req_i[idx] = 1'b0;
    @(posedge wb_clk_i); #1;
    check_eq("done_pulse", {62'd0, done_o, busy_o}, 64'd0);
    check_eq("n_writes", 64'(wr_log.size() - base), div_wr ? 64'd4 : 64'd3);
    k = base;
    if (div_wr) begin
      check_eq("wr_div", {26'd0, wr_log[k]}, {26'd0, 1'b1, 5'h14, 16'h0, div});
      k++;
    end
    check_eq("wr_tx", {26'd0, wr_log[k]}, {26'd0, 1'b1, 5'h00, tx});
    check_eq("wr_ss", {26'd0, wr_log[k+1]}, {26'd0, 1'b1, 5'h18, ss_exp});
    check_eq("wr_ctrl", {26'd0, wr_log[k+2]}, {26'd0, 1'b1, 5'h10, ctrl_noie | IE_V});
    check_eq("rx_reads", 64'(rx_reads - rb), 64'd1);
    check_eq("ctrl_reads", 64'(ctrl_reads - cb), 64'(POLL_READS));
    $display("xfer req%0d tx=%08h len=%0d ss=%0d div=%0d rx=%08h", idx, tx, len, ss, div, rx_data_o);
  endtask

  initial begin
    logic ok;
    int   base;
    wb_rst_i      = 1'b1;
    req_i         = '0;
    req_tx_i      = '0;
    req_len_i     = '0;
    req_ss_i      = '0;
    cfg_divider_i = '0;
    cfg_mode_i    = '0;
    reset_dut();
    @(posedge wb_clk_i); #1;

    run_one(0, 32'hA5A5_0F0F, 6'd32, 5'd2, 16'd4, 3'b000, 32'h1234_5678,
            32'h0000_2120, 32'h0000_0004, 1'b1, 32'h1234_5678);
    run_one(0, 32'hA5A5_0F0F, 6'd32, 5'd2, 16'd4, 3'b000, 32'hCAFE_BABE,
            32'h0000_2120, 32'h0000_0004, 1'b0, 32'hCAFE_BABE);
    run_one(1, 32'h0000_00A7, 6'd8, 5'd0, 16'd7, 3'b101, 32'hFFFF_FF3C,
            32'h0000_2B08, 32'h0000_0001, 1'b1, 32'h0000_003C);
    run_one(0, 32'h5A5A_5A5A, 6'd0, 5'd31, 16'd7, 3'b010, 32'h8765_4321,
            32'h0000_2520, 32'h8000_0000, 1'b0, 32'h8765_4321);
    run_one(1, 32'h0123_4567, 6'd40, 5'd5, 16'd7, 3'b000, 32'h0F0F_F0F0,
            32'h0000_2120, 32'h0000_0020, 1'b0, 32'h0F0F_F0F0);
    run_one(0, 32'h0000_0001, 6'd1, 5'd3, 16'd2, 3'b000, 32'h0000_0003,
            32'h0000_2101, 32'h0000_0008, 1'b1, 32'h0000_0001);

    // Both requesters held high: grants alternate starting from requester 0
    reset_dut();
    @(posedge wb_clk_i); #1;
    req_tx_i      = {32'h0000_2222, 32'h0000_1111};
    req_len_i     = {6'd16, 6'd16};
    req_ss_i      = '0;
    cfg_divider_i = 16'd3;
    cfg_mode_i    = 3'b000;
    miso          = 32'hABCD_1234;
    req_i         = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(ok);
      check_eq($sformatf("alt_gnt%0d", k), {62'd0, done_o}, (k % 2 == 0) ? 64'd1 : 64'd2);
      check_eq($sformatf("alt_rx%0d", k), {32'd0, rx_data_o}, 64'h1234);
      $display("xfer alt%0d done=%b rx=%08h", k, done_o, rx_data_o);
      if (k == 3) req_i = '0;
    end
    @(posedge wb_clk_i); #1;

    // Reset while the transfer is waiting for completion
    hold_int = 1'b1;
    base = wr_log.size();
    req_tx_i[31:0]  = 32'h600D_F00D;
    req_len_i[5:0]  = 6'd32;
    req_ss_i[4:0]   = 5'd2;
    cfg_divider_i   = 16'd3;
    req_i           = 2'b01;
    for (int i = 0; i < 200; i++) begin
      @(posedge wb_clk_i);
      if (wr_log.size() - base >= 3) break;
    end
    check_eq("hold_writes", 64'(wr_log.size() - base), 64'd3);
    repeat (4) @(posedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check_eq("midrst_ctl", {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, done_o, busy_o}, 64'd0);
    check_eq("midrst_dat", {m_dat_o, rx_data_o}, 64'd0);
    req_i = '0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    hold_int = 1'b0;
    @(posedge wb_clk_i); #1;
    $display("xfer reset during wait");
    run_one(0, 32'h600D_F00D, 6'd32, 5'd2, 16'd3, 3'b000, 32'h0BAD_CAFE,
            32'h0000_2120, 32'h0000_0004, 1'b1, 32'h0BAD_CAFE);

    check_eq("bus_protocol", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
